// File: rtl/drac_pkg.sv
// -----------------------------------------------------------------------------
// drac_pkg
//  Core-side request type shared between the CPU load/store path, the
//  next-line prefetch FIFO and the HPDcache CPU request port.
// -----------------------------------------------------------------------------
package drac_pkg;

   typedef struct packed {
      logic [39:0] addr;
      logic [2:0]  size;
      logic        is_store;
      logic [7:0]  tag;
   } req_cpu_dcache_t;

endpackage

// File: rtl/hwpf_pkg.sv
// -----------------------------------------------------------------------------
// hwpf_pkg
//  Types and helpers for the hardware prefetch issue controller.
//  issue_state_t : issue FSM states.
//  cnt_w()       : bit width needed to hold the values 0..max_val (at least 1).
// -----------------------------------------------------------------------------
package hwpf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD,
      COOL
   } issue_state_t;

   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/hwpf_outstanding_cnt.sv
// -----------------------------------------------------------------------------
// hwpf_outstanding_cnt
//  Saturating up/down counter of prefetches issued but not yet answered.
//  Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   inc_i         prefetch handshake this cycle
//   dec_i         prefetch response this cycle
//   count_o       current count (0..MAX_COUNT)
//   at_max_o      count == MAX_COUNT
// -----------------------------------------------------------------------------
module hwpf_outstanding_cnt
   import hwpf_pkg::*;
#(
   parameter int unsigned MAX_COUNT = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        inc_i,
   input  logic                        dec_i,
   output logic [cnt_w(MAX_COUNT)-1:0] count_o,
   output logic                        at_max_o
);

   localparam int unsigned   CW    = cnt_w(MAX_COUNT);
   localparam logic [CW-1:0] MAX_V = CW'(MAX_COUNT);

   logic [CW-1:0] count_q, count_d;

   // Simultaneous inc/dec cancel; decrement at zero and increment at max are dropped.
   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != MAX_V)) begin
         count_d = count_q + CW'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign at_max_o = (count_q == MAX_V);

endmodule

// File: rtl/hwpf_issue_ctrl.sv
// -----------------------------------------------------------------------------
// hwpf_issue_ctrl
//  Issue controller between the next-line prefetch FIFO and the HPDcache CPU
//  request port. Demand requests have priority; prefetches are popped from the
//  FIFO with a one-cycle read pulse, buffered, and presented on the port until
//  accepted. Pops are throttled by the outstanding-prefetch count and by
//  cool-down windows after demand handshakes and after empty pops.
//  Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   enable_i, flush_i            prefetch enable, pipeline flush
//   cpu_req_valid_i/cpu_req_i    demand request in; cpu_req_ready_o accept
//   fifo_read_o, fifo_lock_o     FIFO pop pulse and lock
//   fifo_req_valid_i/fifo_req_i  FIFO registered head
//   dcache_req_valid_o/_o/_pf_o  request to cache (pf_o marks a prefetch)
//   dcache_req_ready_i           cache accepts request
//   dcache_rsp_pf_i              prefetch response returned
//   outstanding_o                in-flight prefetch count
// -----------------------------------------------------------------------------
module hwpf_issue_ctrl
   import hwpf_pkg::*;
   import drac_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned DEMAND_COOLDOWN = 2,
   parameter int unsigned EMPTY_BACKOFF   = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              enable_i,
   input  logic                              flush_i,
   input  logic                              cpu_req_valid_i,
   input  req_cpu_dcache_t                   cpu_req_i,
   output logic                              cpu_req_ready_o,
   output logic                              fifo_read_o,
   output logic                              fifo_lock_o,
   input  logic                              fifo_req_valid_i,
   input  req_cpu_dcache_t                   fifo_req_i,
   output logic                              dcache_req_valid_o,
   output req_cpu_dcache_t                   dcache_req_o,
   output logic                              dcache_req_pf_o,
   input  logic                              dcache_req_ready_i,
   input  logic                              dcache_rsp_pf_i,
   output logic [cnt_w(MAX_OUTSTANDING)-1:0] outstanding_o
);

   localparam int unsigned COOL_MAX = (EMPTY_BACKOFF > DEMAND_COOLDOWN) ? EMPTY_BACKOFF
                                                                       : DEMAND_COOLDOWN;
   localparam int unsigned COOL_W   = cnt_w(COOL_MAX);

   issue_state_t    state_q, state_d;
   req_cpu_dcache_t buf_q, buf_d;
   logic [COOL_W-1:0] cool_q, cool_d;

   logic in_hold;
   logic pf_hs;
   logic demand_hs;
   logic pop_ok;
   logic at_max;

   hwpf_outstanding_cnt #(
      .MAX_COUNT(MAX_OUTSTANDING)
   ) u_outstanding_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (pf_hs),
      .dec_i   (dcache_rsp_pf_i),
      .count_o (outstanding_o),
      .at_max_o(at_max)
   );

   assign fifo_lock_o = !enable_i;

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cool_d      = cool_q;
      fifo_read_o = 1'b0;

      in_hold = (state_q == HOLD);

      // Port mux: the buffered prefetch owns the port in HOLD; flush withdraws it
      // combinationally, which is the only way a presented prefetch may vanish.
      dcache_req_valid_o = in_hold ? !flush_i : cpu_req_valid_i;
      dcache_req_o       = in_hold ? buf_q : cpu_req_i;
      dcache_req_pf_o    = in_hold && !flush_i;
      cpu_req_ready_o    = in_hold ? 1'b0 : dcache_req_ready_i;

      pf_hs     = in_hold && !flush_i && dcache_req_ready_i;
      demand_hs = !in_hold && cpu_req_valid_i && dcache_req_ready_i;
      pop_ok    = enable_i && !cpu_req_valid_i && !at_max && !flush_i;

      unique case (state_q)
         IDLE: begin
            if (pop_ok) begin
               fifo_read_o = 1'b1;
               state_d     = WAIT;
            end else if (demand_hs && (DEMAND_COOLDOWN != 0)) begin
               cool_d  = COOL_W'(DEMAND_COOLDOWN);
               state_d = COOL;
            end
         end
         WAIT: begin
            if (fifo_req_valid_i) begin
               buf_d   = fifo_req_i;
               state_d = HOLD;
            end else if (EMPTY_BACKOFF != 0) begin
               cool_d  = COOL_W'(EMPTY_BACKOFF);
               state_d = COOL;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (pf_hs) begin
               state_d = IDLE;
            end
         end
         COOL: begin
            // A demand handshake restarts the window even if more remained.
            if (demand_hs && (DEMAND_COOLDOWN != 0)) begin
               cool_d = COOL_W'(DEMAND_COOLDOWN);
            end else if (cool_q <= COOL_W'(1)) begin
               cool_d  = '0;
               state_d = IDLE;
            end else begin
               cool_d = cool_q - COOL_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush_i) begin
         state_d = IDLE;
         buf_d   = '0;
         cool_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         buf_q   <= '0;
         cool_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cool_q  <= cool_d;
      end
   end

endmodule

// File: tb/tb_hwpf_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hwpf_issue_ctrl
//  Directed, table-driven bench for hwpf_issue_ctrl with default parameters
//  (MAX_OUTSTANDING=4, DEMAND_COOLDOWN=2, EMPTY_BACKOFF=8). Each table row is
//  one clock cycle: inputs driven after the edge, outputs sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_hwpf_issue_ctrl;
   import drac_pkg::*;

   logic            clk;
   logic            rst;
   logic            en;
   logic            fl;
   logic            cv;
   req_cpu_dcache_t cpu_req;
   logic            crdy;
   logic            rd;
   logic            lock;
   logic            fv;
   req_cpu_dcache_t fifo_req;
   logic            dv;
   req_cpu_dcache_t dreq;
   logic            pf;
   logic            rdy;
   logic            rsp;
   logic [2:0]      outs;

   int n_tests = 0;
   int n_fail  = 0;

   hwpf_issue_ctrl #(
      .MAX_OUTSTANDING(4),
      .DEMAND_COOLDOWN(2),
      .EMPTY_BACKOFF  (8)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .enable_i          (en),
      .flush_i           (fl),
      .cpu_req_valid_i   (cv),
      .cpu_req_i         (cpu_req),
      .cpu_req_ready_o   (crdy),
      .fifo_read_o       (rd),
      .fifo_lock_o       (lock),
      .fifo_req_valid_i  (fv),
      .fifo_req_i        (fifo_req),
      .dcache_req_valid_o(dv),
      .dcache_req_o      (dreq),
      .dcache_req_pf_o   (pf),
      .dcache_req_ready_i(rdy),
      .dcache_rsp_pf_i   (rsp),
      .outstanding_o     (outs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en, fl, cv, fv, rdy, rsp;
      logic [7:0] ftag;
      logic       e_rd, e_dv, e_pf, e_crdy;
      logic [7:0] e_tag;
      logic [2:0] e_outs;
   } vec_t;

   vec_t vecs[41];

   function automatic vec_t mk(input logic i_en, i_fl, i_cv, i_fv, i_rdy, i_rsp,
                               input logic [7:0] i_ftag,
                               input logic x_rd, x_dv, x_pf, x_crdy,
                               input logic [7:0] x_tag, input logic [2:0] x_outs);
      vec_t v;
      v.en = i_en; v.fl = i_fl; v.cv = i_cv; v.fv = i_fv; v.rdy = i_rdy; v.rsp = i_rsp;
      v.ftag = i_ftag;
      v.e_rd = x_rd; v.e_dv = x_dv; v.e_pf = x_pf; v.e_crdy = x_crdy;
      v.e_tag = x_tag; v.e_outs = x_outs;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_fifo(input logic [7:0] tag);
      fifo_req      = '0;
      fifo_req.addr = {32'h0000_1000, tag};
      fifo_req.size = 3'd3;
      fifo_req.tag  = tag;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int reads;
      int lock_bad;

      // Demand request is fixed; its tag C0 distinguishes it from prefetch tags.
      cpu_req          = '0;
      cpu_req.addr     = 40'h00_0000_2000;
      cpu_req.size     = 3'd2;
      cpu_req.is_store = 1'b1;
      cpu_req.tag      = 8'hC0;

      rst = 1'b1; en = 1'b0; fl = 1'b0; cv = 1'b0; fv = 1'b0; rdy = 1'b1; rsp = 1'b0;
      drive_fifo(8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      check("reset_rd",   rd,   1'b0);
      check("reset_dv",   dv,   1'b0);
      check("reset_pf",   pf,   1'b0);
      check("reset_outs", outs, 3'd0);
      check("reset_crdy", crdy, 1'b1);
      check("reset_lock", lock, 1'b1);
      next_cycle();

      //              en fl cv fv rdy rsp ftag     rd dv pf crdy tag    outs
      // Pop A1, prefetch on port two cycles later.
      vecs[0]  = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd0);
      vecs[1]  = mk(1, 0, 0, 1, 1, 0, 8'hA1,   0, 0, 0, 1, 8'h00, 3'd0);
      vecs[2]  = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 1, 1, 0, 8'hA1, 3'd0);
      // Pop A2 while a demand waits; HOLD stalls with ready low, buffer stable.
      vecs[3]  = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd1);
      vecs[4]  = mk(1, 0, 1, 1, 0, 0, 8'hA2,   0, 1, 0, 0, 8'hC0, 3'd1);
      vecs[5]  = mk(1, 0, 1, 0, 0, 0, 8'h00,   0, 1, 1, 0, 8'hA2, 3'd1);
      vecs[6]  = mk(1, 0, 1, 1, 0, 0, 8'h55,   0, 1, 1, 0, 8'hA2, 3'd1);
      vecs[7]  = mk(1, 0, 1, 0, 0, 0, 8'h00,   0, 1, 1, 0, 8'hA2, 3'd1);
      vecs[8]  = mk(1, 0, 1, 0, 1, 0, 8'h00,   0, 1, 1, 0, 8'hA2, 3'd1);
      // Demand issues next cycle, then two cool-down cycles.
      vecs[9]  = mk(1, 0, 1, 0, 1, 0, 8'h00,   0, 1, 0, 1, 8'hC0, 3'd2);
      vecs[10] = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 0, 0, 1, 8'h00, 3'd2);
      vecs[11] = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 0, 0, 1, 8'h00, 3'd2);
      // Empty pop at row 12, back-off, next pulse ten cycles later.
      vecs[12] = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd2);
      vecs[13] = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 0, 0, 1, 8'h00, 3'd2);
      for (int i = 14; i <= 21; i++) begin
         vecs[i] = mk(1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 3'd2);
      end
      vecs[22] = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd2);
      vecs[23] = mk(1, 0, 0, 1, 1, 0, 8'hA3,   0, 0, 0, 1, 8'h00, 3'd2);
      vecs[24] = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 1, 1, 0, 8'hA3, 3'd2);
      // Handshake with simultaneous response keeps the count at 3.
      vecs[25] = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd3);
      vecs[26] = mk(1, 0, 0, 1, 1, 0, 8'hA4,   0, 0, 0, 1, 8'h00, 3'd3);
      vecs[27] = mk(1, 0, 0, 0, 1, 1, 8'h00,   0, 1, 1, 0, 8'hA4, 3'd3);
      vecs[28] = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd3);
      vecs[29] = mk(1, 0, 0, 1, 1, 0, 8'hA5,   0, 0, 0, 1, 8'h00, 3'd3);
      vecs[30] = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 1, 1, 0, 8'hA5, 3'd3);
      // Saturated at 4: no pops until a lone response brings it to 3.
      vecs[31] = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 0, 0, 1, 8'h00, 3'd4);
      vecs[32] = mk(1, 0, 0, 0, 1, 0, 8'h00,   0, 0, 0, 1, 8'h00, 3'd4);
      vecs[33] = mk(1, 0, 0, 0, 1, 1, 8'h00,   0, 0, 0, 1, 8'h00, 3'd4);
      vecs[34] = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd3);
      vecs[35] = mk(1, 0, 0, 1, 1, 0, 8'hA6,   0, 0, 0, 1, 8'h00, 3'd3);
      // Flush in HOLD withdraws the prefetch the same cycle; back to IDLE.
      vecs[36] = mk(1, 1, 0, 0, 1, 0, 8'h00,   0, 0, 0, 0, 8'h00, 3'd3);
      vecs[37] = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd3);
      // Flush in WAIT drops the popped entry.
      vecs[38] = mk(1, 1, 0, 1, 1, 0, 8'hA7,   0, 0, 0, 1, 8'h00, 3'd3);
      vecs[39] = mk(1, 0, 0, 0, 1, 0, 8'h00,   1, 0, 0, 1, 8'h00, 3'd3);
      vecs[40] = mk(0, 0, 0, 0, 1, 0, 8'h00,   0, 0, 0, 1, 8'h00, 3'd3);

      for (int i = 0; i < 41; i++) begin
         en = vecs[i].en; fl = vecs[i].fl; cv = vecs[i].cv; fv = vecs[i].fv;
         rdy = vecs[i].rdy; rsp = vecs[i].rsp;
         drive_fifo(vecs[i].ftag);
         #3;
         check($sformatf("row%0d_rd", i),   rd,   vecs[i].e_rd);
         check($sformatf("row%0d_dv", i),   dv,   vecs[i].e_dv);
         check($sformatf("row%0d_pf", i),   pf,   vecs[i].e_pf);
         check($sformatf("row%0d_crdy", i), crdy, vecs[i].e_crdy);
         check($sformatf("row%0d_outs", i), outs, vecs[i].e_outs);
         check($sformatf("row%0d_lock", i), lock, !vecs[i].en);
         if (vecs[i].e_dv) begin
            check($sformatf("row%0d_tag", i), dreq.tag, vecs[i].e_tag);
         end
         next_cycle();
      end

      // Mid-operation reset (state COOL, three outstanding) clears everything.
      rst = 1'b1; en = 1'b1; fl = 1'b0; cv = 1'b0; fv = 1'b0; rsp = 1'b0;
      next_cycle();
      rst = 1'b0;
      #3;
      check("midrst_outs", outs, 3'd0);
      check("midrst_pop",  rd,   1'b1);
      check("midrst_dv",   dv,   1'b0);
      next_cycle();

      // Disabled: locked FIFO, no pops over 50 idle cycles; response at zero ignored.
      reads    = 0;
      lock_bad = 0;
      for (int c = 0; c < 50; c++) begin
         en  = 1'b0;
         rsp = (c == 0);
         #3;
         if (rd)    reads++;
         if (!lock) lock_bad++;
         next_cycle();
      end
      rsp = 1'b0;
      check("dis_reads",    reads,    0);
      check("dis_lock",     lock_bad, 0);
      check("dis_outs_dec0", outs,    3'd0);

      // Demand still passes while disabled.
      cv  = 1'b1;
      rdy = 1'b1;
      #3;
      check("dis_dem_dv",   dv,       1'b1);
      check("dis_dem_crdy", crdy,     1'b1);
      check("dis_dem_pf",   pf,       1'b0);
      check("dis_dem_tag",  dreq.tag, 8'hC0);
      check("dis_dem_rd",   rd,       1'b0);
      next_cycle();
      cv = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
